surf_cmd_transmitter: RTL
=========================

# surf_cmd_transmitter

TURF-side serializer that drives the single-wire SURF command line. On each accepted request it latches a 2-bit LAB buffer ID and a 32-bit event ID and sends a 7-byte frame: header, LAB ID, event ID MSB first, then checksum. Each byte is sent as 8N1 UART at CLKS_PER_BIT clocks per bit. The SURF command receiver, whose UART oversamples 16x on every clock, decodes this frame directly.

## Interface
Parameters:
- CLKS_PER_BIT, 16, clock cycles per serial bit; must be ≥ 2 and match the receiver's 16x oversampling (16 at 33 MHz).
- TX_HEADER, 8'hA6, frame header byte.

Ports:
- clk33_i  input  1  system clock (33 MHz); only clock.
- rst_i  input  1  reset; one clock, reset asynchronous, active-high.
- send_i  input  1  request strobe; accepted on any rising edge where busy_o=0.
- lab_id_i  input  2  LAB buffer ID; sampled on accept.
- event_id_i  input  32  event ID; sampled on accept.
- busy_o  output  1  frame in progress; new requests are ignored while high.
- done_o  output  1  one-cycle pulse when the last stop bit completes.
- cmd_o  output  1  registered serial line; idles high.

## Operation
- Frame byte order (index 0–6): TX_HEADER; {6'b0, lab_id}; eid[31:24]; eid[23:16]; eid[15:8]; eid[7:0]; checksum.
- Checksum = (eid[31:24]+eid[23:16]+eid[15:8]+eid[7:0]) mod 256.
  - Header and LAB byte are excluded.
  - Computed from the latched value; 8-bit wrap, carries discarded.
- Byte format: start bit 0, data LSB first (8 bits), stop bit 1. No gap between bytes: the next start bit follows the stop bit directly.
- State machine:
  - IDLE: cmd_o=1. On send_i, latch inputs, set byte_idx=0, go to START.
  - START: cmd_o=0 for CLKS_PER_BIT cycles, then go to DATA with bit_idx=0.
  - DATA: cmd_o=byte[bit_idx] for CLKS_PER_BIT cycles per bit. After bit 7, go to STOP.
  - STOP: cmd_o=1 for CLKS_PER_BIT cycles. Then:
    - if byte_idx<6: increment byte_idx and go to START;
    - if byte_idx=6: pulse done_o and go to IDLE.
- Counters:
  - bit-time counter: width clog2(CLKS_PER_BIT), resets to 0 on every bit boundary;
  - bit_idx: 3 bits;
  - byte_idx: 3 bits, stays within 0–6.
- Inputs that change after accept do not affect the frame in flight.
- send_i held high continuously produces back-to-back frames, each accepted in the cycle busy_o drops.
- Reset while a frame is in flight:
  - the frame is abandoned; cmd_o=1, busy_o=0, done_o=0 immediately (asynchronous);
  - first accept is possible on the first rising edge after rst_i deasserts.
- The receiver recovers from a truncated frame by hunting for the header, so no abort marker is sent.

## Timing
- Reset values: cmd_o=1, busy_o=0, done_o=0, state IDLE, all counters 0.
- Cycle 0: edge where send_i=1 and busy_o=0.
- Cycle 1: busy_o=1 and cmd_o=0 (header start bit). Input-to-line latency is one cycle.
- Bit k of the frame (k=0..69, 10 bits per byte) occupies cycles 1+k·CLKS_PER_BIT through (k+1)·CLKS_PER_BIT.
- Full frame: 70·CLKS_PER_BIT cycles; 1120 at the default.
- Cycle 70·CLKS_PER_BIT+1 (1121): done_o=1 for one cycle, busy_o=0, cmd_o=1.
  - send_i is accepted in this same cycle if asserted.
  - The next start bit then appears at cycle 1122, giving a minimum of one idle-high cycle between frames.
- send_i while busy_o=1 is dropped, not queued.
- send_i coincident with rst_i: reset wins and the request is dropped.

## Test plan
- Reset idle: hold rst_i, release, run 100 cycles with no send_i → cmd_o=1, busy_o=0, done_o=0 throughout.
- Basic frame, lab_id=2'b10, event_id=32'h12345678:
  - line bytes decode to A6, 02, 12, 34, 56, 78, 14 (0x114 mod 256);
  - every bit exactly 16 cycles;
  - done_o pulses at cycle 1121.
- Checksum wrap, event_id=32'hFFFFFFFF, lab_id=3 → bytes A6, 03, FF, FF, FF, FF, FC.
- Busy rejection and latching:
  - send_i again at cycle 500 with a different event_id → ignored; exactly one frame is sent;
  - changing event_id_i at cycle 2 does not alter the bytes on the line.
- Back-to-back: send_i held high for two frames (event IDs 1 then 2) → second start bit at cycle 1122; both frames decode correctly, with checksums 01 and 02.
- Mid-frame reset: assert rst_i at cycle 400 → cmd_o=1 and busy_o=0 asynchronously; a new send after release produces a complete, correct frame.
- End-to-end: connect cmd_o to the SURF command receiver → its event ID output equals the sent value, checksum-OK is high, and the digitize flag matching lab_id pulses.

Source files
------------

// File: rtl/surf_cmd_transmitter.sv
// surf_cmd_transmitter
// TURF-side serializer for the single-wire SURF command line. Each accepted
// request latches a LAB buffer ID and an event ID and sends a 7-byte frame
// (header, LAB ID, event ID MSB first, checksum) as back-to-back 8N1 UART
// bytes at CLKS_PER_BIT clocks per bit.
//
// Ports:
//   clk33_i     system clock (33 MHz)
//   rst_i       asynchronous active-high reset; abandons any frame in flight
//   send_i      request strobe, accepted on a rising edge while busy_o=0
//   lab_id_i    LAB buffer ID, sampled on accept
//   event_id_i  event ID, sampled on accept
//   busy_o      frame in progress; requests are dropped while high
//   done_o      one-cycle pulse after the last stop bit completes
//   cmd_o       registered serial line, idles high
module surf_cmd_transmitter #(
  parameter int unsigned CLKS_PER_BIT = 16,
  parameter logic [7:0]  TX_HEADER    = 8'hA6
) (
  input  logic        clk33_i,
  input  logic        rst_i,
  input  logic        send_i,
  input  logic [1:0]  lab_id_i,
  input  logic [31:0] event_id_i,
  output logic        busy_o,
  output logic        done_o,
  output logic        cmd_o
);

  localparam int unsigned CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(CLKS_PER_BIT - 1);
  localparam logic [2:0]    LAST_BYTE = 3'd6;

  typedef enum logic [1:0] {
    IDLE,
    START,
    DATA,
    STOP
  } state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0]    bit_q, bit_d;
  logic [2:0]    byte_q, byte_d;
  logic [1:0]    lab_q, lab_d;
  logic [31:0]   eid_q, eid_d;
  logic          cmd_q, cmd_d;
  logic          done_q, done_d;

  logic [7:0]    csum;
  logic [7:0]    cur_byte;
  logic          bit_end;

  assign csum    = eid_q[31:24] + eid_q[23:16] + eid_q[15:8] + eid_q[7:0];
  assign bit_end = (cnt_q == CNT_LAST);

  always_comb begin
    cur_byte = TX_HEADER;
    case (byte_q)
      3'd0:    cur_byte = TX_HEADER;
      3'd1:    cur_byte = {6'b0, lab_q};
      3'd2:    cur_byte = eid_q[31:24];
      3'd3:    cur_byte = eid_q[23:16];
      3'd4:    cur_byte = eid_q[15:8];
      3'd5:    cur_byte = eid_q[7:0];
      3'd6:    cur_byte = csum;
      default: cur_byte = TX_HEADER;
    endcase
  end

  // cmd_o is registered, so each branch computes the line level for the
  // cycle after the edge: on a bit boundary that is already the next bit.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    bit_d   = bit_q;
    byte_d  = byte_q;
    lab_d   = lab_q;
    eid_d   = eid_q;
    cmd_d   = 1'b1;
    done_d  = 1'b0;

    case (state_q)
      IDLE: begin
        if (send_i) begin
          lab_d   = lab_id_i;
          eid_d   = event_id_i;
          byte_d  = '0;
          bit_d   = '0;
          cnt_d   = '0;
          cmd_d   = 1'b0;
          state_d = START;
        end
      end

      START: begin
        cmd_d = 1'b0;
        if (bit_end) begin
          cnt_d   = '0;
          bit_d   = '0;
          cmd_d   = cur_byte[0];
          state_d = DATA;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end

      DATA: begin
        cmd_d = cur_byte[bit_q];
        if (bit_end) begin
          cnt_d = '0;
          if (bit_q == 3'd7) begin
            cmd_d   = 1'b1;
            state_d = STOP;
          end else begin
            bit_d = bit_q + 3'd1;
            cmd_d = cur_byte[bit_q + 3'd1];
          end
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end

      STOP: begin
        cmd_d = 1'b1;
        if (bit_end) begin
          cnt_d = '0;
          if (byte_q == LAST_BYTE) begin
            done_d  = 1'b1;
            state_d = IDLE;
          end else begin
            byte_d  = byte_q + 3'd1;
            cmd_d   = 1'b0;
            state_d = START;
          end
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk33_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      bit_q   <= '0;
      byte_q  <= '0;
      lab_q   <= '0;
      eid_q   <= '0;
      cmd_q   <= 1'b1;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      byte_q  <= byte_d;
      lab_q   <= lab_d;
      eid_q   <= eid_d;
      cmd_q   <= cmd_d;
      done_q  <= done_d;
    end
  end

  assign busy_o = (state_q != IDLE);
  assign done_o = done_q;
  assign cmd_o  = cmd_q;

endmodule
